// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier arbiter: funct3 codes, sequencer states
// and the two-way round-robin pick used by rr_arb2.
package mul_pkg;

    localparam logic [2:0] MUL_OP_MUL    = 3'b000;
    localparam logic [2:0] MUL_OP_MULH   = 3'b001;
    localparam logic [2:0] MUL_OP_MULHSU = 3'b010;
    localparam logic [2:0] MUL_OP_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2
    } mul_arb_state_t;

    localparam int unsigned MUL_LATENCY = 32'd5;

    // last=1 means requester 1 was granted most recently, so requester 0 wins a tie.
    function automatic logic [1:0] rr_pick(input logic [1:0] eligible, input logic last);
        logic [1:0] grant;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer
// that only advances when the grant is actually taken.
module rr_arb2
    import mul_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eligible,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_r;

    // Grant decode from current eligibility and the last-grant pointer.
    always_comb begin
        grant = rr_pick(eligible, last_r);
    end

    // Last-grant pointer, moved only on a taken grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (accept) begin
            last_r <= grant[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one sequential multiplier between two requesters: round-robin accept,
// start/operand hold sequencing, and a one-entry response buffer per requester.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [2:0]      req0_op,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [2:0]      req1_op,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [XLEN-1:0] resp0_result,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp1_result,
    output logic            mul_start,
    output logic [2:0]      mul_op,
    output logic [XLEN-1:0] mul_op1,
    output logic [XLEN-1:0] mul_op2,
    input  logic [XLEN-1:0] mul_result,
    input  logic            mul_done
);

    mul_arb_state_t  state_r;
    mul_arb_state_t  state_s;
    logic [1:0]      eligible_s;
    logic [1:0]      grant_s;
    logic            accept_s;
    logic            id_r;
    logic [2:0]      op_r;
    logic [XLEN-1:0] op1_r;
    logic [XLEN-1:0] op2_r;
    logic            start_r;
    logic            resp0_valid_r;
    logic            resp1_valid_r;
    logic [XLEN-1:0] resp0_result_r;
    logic [XLEN-1:0] resp1_result_r;

    // A full buffer blocks its owner, even in the cycle it is being popped.
    always_comb begin
        eligible_s = {req1_valid & ~resp1_valid_r, req0_valid & ~resp0_valid_r};
    end

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible_s),
        .accept   (accept_s),
        .grant    (grant_s)
    );

    // Acceptance and per-port ready; nothing is accepted while reset is asserted.
    always_comb begin
        accept_s   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && (state_r == IDLE)) begin
            accept_s   = |grant_s;
            req0_ready = grant_s[0];
            req1_ready = grant_s[1];
        end else begin
            accept_s   = 1'b0;
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Sequencer next state; a stray mul_done outside RUN has no effect.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (mul_done) begin
                    state_s = SETTLE;
                end else begin
                    state_s = RUN;
                end
            end
            SETTLE:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State and start registers; start mirrors RUN one-for-one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            start_r <= 1'b0;
        end else begin
            state_r <= state_s;
            start_r <= (state_s == RUN);
        end
    end

    // Request capture; held until the next acceptance so mul sees stable op/operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_r  <= 1'b0;
            op_r  <= 3'b000;
            op1_r <= '0;
            op2_r <= '0;
        end else if (accept_s) begin
            id_r  <= grant_s[1];
            op_r  <= grant_s[1] ? req1_op  : req0_op;
            op1_r <= grant_s[1] ? req1_op1 : req0_op1;
            op2_r <= grant_s[1] ? req1_op2 : req0_op2;
        end else begin
            id_r  <= id_r;
            op_r  <= op_r;
            op1_r <= op1_r;
            op2_r <= op2_r;
        end
    end

    // Response buffer 0: filled on SETTLE exit, drained by the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp0_valid_r  <= 1'b0;
            resp0_result_r <= '0;
        end else if ((state_r == SETTLE) && (id_r == 1'b0)) begin
            resp0_valid_r  <= 1'b1;
            resp0_result_r <= mul_result;
        end else if (resp0_valid_r && resp0_ready) begin
            resp0_valid_r  <= 1'b0;
            resp0_result_r <= resp0_result_r;
        end else begin
            resp0_valid_r  <= resp0_valid_r;
            resp0_result_r <= resp0_result_r;
        end
    end

    // Response buffer 1: same discipline as buffer 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp1_valid_r  <= 1'b0;
            resp1_result_r <= '0;
        end else if ((state_r == SETTLE) && (id_r == 1'b1)) begin
            resp1_valid_r  <= 1'b1;
            resp1_result_r <= mul_result;
        end else if (resp1_valid_r && resp1_ready) begin
            resp1_valid_r  <= 1'b0;
            resp1_result_r <= resp1_result_r;
        end else begin
            resp1_valid_r  <= resp1_valid_r;
            resp1_result_r <= resp1_result_r;
        end
    end

    assign mul_start    = start_r;
    assign mul_op       = op_r;
    assign mul_op1      = op1_r;
    assign mul_op2      = op2_r;
    assign resp0_valid  = resp0_valid_r;
    assign resp0_result = resp0_result_r;
    assign resp1_valid  = resp1_valid_r;
    assign resp1_result = resp1_result_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized self-checking bench for mul_arbiter with a behavioural mul stand-in
// and a transaction-level reference model of arbitration and latency.
module tb_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op, mul_op;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [31:0] resp0_result, resp1_result;
    logic        mul_start, mul_done;
    logic [31:0] mul_op1, mul_op2, mul_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .mul_start(mul_start), .mul_op(mul_op), .mul_op1(mul_op1), .mul_op2(mul_op2),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    // RISC-V M result from 64-bit modular arithmetic.
    function automatic logic [31:0] ref_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        sa = {{32{a[31]}}, a};
        ua = {32'd0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        case (op[1:0])
            2'b00:   begin p = sa * sb; return p[31:0];  end
            2'b01:   begin p = sa * sb; return p[63:32]; end
            2'b10:   begin p = sa * ub; return p[63:32]; end
            default: begin p = ua * ub; return p[63:32]; end
        endcase
    endfunction

    // mul stand-in: done on the third start-high cycle, result correct only once settled.
    logic [2:0] mcnt;
    always @(posedge clk) begin
        if (!rst_n || !mul_start) mcnt <= 3'd0;
        else                      mcnt <= mcnt + 3'd1;
    end
    assign mul_done   = mul_start && (mcnt == 3'd2);
    assign mul_result = (mcnt == 3'd3) ? ref_mul(mul_op, mul_op1, mul_op2)
                                       : ~ref_mul(mul_op, mul_op1, mul_op2);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          cyc = 0;
    bit          busy = 1'b0;
    int          acc_cyc = -100;
    bit          acc_id;
    logic [31:0] acc_res, acc_op1;
    bit          full [2];
    logic [31:0] rval [2];
    bit          last = 1'b1;
    int          glog_id [$];
    int          glog_cyc [$];

    // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        bit e0, e1, g0, g1, st;
        #1;
        if (busy && cyc == acc_cyc + 5) begin
            full[acc_id] = 1'b1;
            rval[acc_id] = acc_res;
            busy = 1'b0;
        end
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst_n) begin
            chk("resp0_valid", {31'd0, resp0_valid}, {31'd0, full[0]});
            chk("resp1_valid", {31'd0, resp1_valid}, {31'd0, full[1]});
            chk("resp0_result", resp0_result, rval[0]);
            chk("resp1_result", resp1_result, rval[1]);
            st = busy && (cyc > acc_cyc) && (cyc <= acc_cyc + 3);
            chk("mul_start", {31'd0, mul_start}, {31'd0, st});
            if (busy && cyc > acc_cyc) chk("mul_op1_hold", mul_op1, acc_op1);
            e0 = req0_valid && !full[0] && !busy;
            e1 = req1_valid && !full[1] && !busy;
            g0 = e0 && (!e1 || last);
            g1 = e1 && (!e0 || !last);
        end
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
        @(posedge clk);
        if (!rst_n) begin
            busy = 1'b0; full[0] = 1'b0; full[1] = 1'b0;
            rval[0] = 32'd0; rval[1] = 32'd0; last = 1'b1;
        end else begin
            if (full[0] && resp0_ready) full[0] = 1'b0;
            if (full[1] && resp1_ready) full[1] = 1'b0;
            if (g0 || g1) begin
                busy    = 1'b1;
                acc_cyc = cyc;
                acc_id  = g1;
                acc_res = g1 ? ref_mul(req1_op, req1_op1, req1_op2) : ref_mul(req0_op, req0_op1, req0_op2);
                acc_op1 = g1 ? req1_op1 : req0_op1;
                last    = g1;
                glog_id.push_back(int'(g1));
                glog_cyc.push_back(cyc);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(4, 0))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'($urandom_range(9, 0));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 3'b000; req1_op = 3'b000;
        req0_op1 = 32'd0; req0_op2 = 32'd0; req1_op1 = 32'd0; req1_op2 = 32'd0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        @(negedge clk);
        run(2);
        rst_n = 1'b1;
        chk("reset_resp0_valid", {31'd0, resp0_valid}, 32'd0);
        chk("reset_mul_start", {31'd0, mul_start}, 32'd0);
        chk("reset_mul_op1", mul_op1, 32'd0);
        run(1);

        // MUL 7x6 on port 0
        req0_valid = 1'b1; req0_op = 3'b000; req0_op1 = 32'd7; req0_op2 = 32'd6;
        step();
        req0_valid = 1'b0;
        run(4);
        chk("mul7x6_valid", {31'd0, resp0_valid}, 32'd1);
        chk("mul7x6_result", resp0_result, 32'd42);
        resp0_ready = 1'b1;
        run(2);

        // MULH -3 x 5 on port 1
        req1_valid = 1'b1; req1_op = 3'b001; req1_op1 = 32'hFFFF_FFFD; req1_op2 = 32'd5;
        step();
        req1_valid = 1'b0;
        run(4);
        chk("mulh_result", resp1_result, 32'hFFFF_FFFF);
        resp1_ready = 1'b1;
        run(2);

        // Both ports streaming MULHU
        glog_id.delete(); glog_cyc.delete();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 3'b011; req1_op = 3'b011;
        req0_op1 = 32'hFFFF_FFFF; req0_op2 = 32'hFFFF_FFFF;
        req1_op1 = 32'hFFFF_FFFF; req1_op2 = 32'hFFFF_FFFF;
        run(20);
        chk("stream_grants", 32'(glog_id.size()), 32'd4);
        for (int k = 0; k < 4 && k < glog_id.size(); k++)
            chk("stream_alt", 32'(glog_id[k]), 32'(k % 2));
        for (int k = 1; k < 4 && k < glog_cyc.size(); k++)
            chk("stream_spacing", 32'(glog_cyc[k] - glog_cyc[k-1]), 32'd5);

        // Port 0 response withheld: only port 1 proceeds until the pop
        resp0_ready = 1'b0;
        run(30);
        chk("blocked_owner_full", {31'd0, resp0_valid}, 32'd1);
        resp0_ready = 1'b1;
        run(12);
        req0_valid = 1'b0; req1_valid = 1'b0;
        run(8);

        // Reset during RUN abandons the op
        req0_valid = 1'b1; req0_op = 3'b000; req0_op1 = 32'd11; req0_op2 = 32'd13;
        step();
        req0_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_run_start", {31'd0, mul_start}, 32'd0);
        chk("rst_run_resp0", {31'd0, resp0_valid}, 32'd0);
        run(6);
        chk("rst_run_no_resp", {31'd0, resp0_valid}, 32'd0);
        req0_valid = 1'b1; req0_op1 = 32'd3; req0_op2 = 32'd3;
        step();
        req0_valid = 1'b0;
        run(4);
        chk("mul3x3_result", resp0_result, 32'd9);
        run(2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst_n       = ($urandom_range(299, 0) != 0);
            req0_valid  = $urandom_range(1, 0) == 1;
            req1_valid  = $urandom_range(1, 0) == 1;
            resp0_ready = $urandom_range(2, 0) != 0;
            resp1_ready = $urandom_range(2, 0) != 0;
            req0_op  = 3'($urandom_range(3, 0));
            req1_op  = 3'($urandom_range(3, 0));
            req0_op1 = pick_operand(); req0_op2 = pick_operand();
            req1_op1 = pick_operand(); req1_op2 = pick_operand();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Two-port arbiter and sequencer that shares one `mul` instance between two requesters, for example the integer pipeline and a coprocessor port. It accepts requests round-robin and drives the multiplier's `start`/`op`/operand pins with the hold discipline that unit needs. It captures the result only after both `mul_temp` and `mul_temp_invert` have settled, and returns it through a one-entry response buffer per requester.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; must match the `size` of the attached `mul`.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low; the same net drives the attached `mul`.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid is also high.
- `req0_op` / `req1_op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- `req0_op1`, `req0_op2` / `req1_op1`, `req1_op2`  in  XLEN  operands.
- `resp0_valid` / `resp1_valid`  out  1  response buffer full.
- `resp0_ready` / `resp1_ready`  in  1  requester consumes the response.
- `resp0_result` / `resp1_result`  out  XLEN  captured result.
- `mul_start`  out  1  to `mul.start`.
- `mul_op`  out  3  to `mul.op`.
- `mul_op1`, `mul_op2`  out  XLEN  to `mul.op1` and `mul.op2`.
- `mul_result`  in  XLEN  from `mul.result`.
- `mul_done`  in  1  from `mul.done`.

## Operation
- State machine with three states:
  - IDLE: accepts a request.
  - RUN: `mul_start`=1 and operands held.
  - SETTLE: `mul_start`=0, operands and op still held; the result is captured here.
- Transitions:
  - IDLE→RUN on an accepted request.
  - RUN→SETTLE on `mul_done`.
  - SETTLE→IDLE unconditionally, writing `mul_result` into the granted requester's response buffer.
- Eligibility: requester i is eligible when `reqi_valid`=1 and `respi_valid`=0, using the current-cycle full flag.
- A buffer being popped this cycle still counts as full; the requester becomes eligible on the next cycle.
- Round-robin grant:
  - If only one requester is eligible, it is granted.
  - If both are eligible, grant goes to the requester that was not granted last.
  - The `last` pointer updates only on acceptance; reset value `last`=1, so requester 0 wins the first tie.
- `reqi_ready` = (state==IDLE) & granted i. It is combinational from both valids and the full flags. At most one ready is high per cycle.
- On acceptance, latch requester id, op, op1 and op2 into internal registers.
- `mul_op`, `mul_op1` and `mul_op2` are driven from these registers in every state. They stay stable from RUN through the end of SETTLE, because `mul.result` decodes `op` and the operand sign bits combinationally.
- Response buffer i:
  - Set on the SETTLE exit for id i.
  - Cleared when `respi_valid` and `respi_ready` are both high.
  - Set and clear never coincide, because the buffer is full only when not granted.
- Results are bit-exact RISC-V M semantics as produced by `mul`. The arbiter performs no arithmetic on data.

## Timing
- Reset values: state IDLE, `last`=1, every `reqi_ready`=0 while `rst_n`=0.
- Other outputs while `rst_n`=0: `mul_start`=0, `resp*_valid`=0, `resp*_result`=0, `mul_op*`=0.
- Reset mid-RUN or mid-SETTLE abandons the operation; no response is produced.
- Cycle map, with acceptance at edge E0:
  - C1: RUN, `mul_start`=1.
  - C3: `mul_done`=1.
  - C4: SETTLE, `mul_start`=0.
  - At E4 the result is captured; `mul_temp_invert` is valid from C4.
  - C5: `resp_valid`=1 and IDLE, so a new acceptance can occur at E5.
- Latency is 5 cycles from acceptance to `resp_valid`. Peak throughput is 1 op per 5 cycles.
- SETTLE provides the single `start`-low cycle that returns the `mul` counter to 0 before the next op.
- A `mul_done` outside RUN is ignored.
- A response is held indefinitely until it is consumed. Its owner is blocked while it is held; the other requester proceeds.

## Structure
- Shared package `mul_pkg`:
  - funct3 constants `MUL_OP_MUL`, `MUL_OP_MULH`, `MUL_OP_MULHSU`, `MUL_OP_MULHU`.
  - State enum `mul_arb_state_t` {IDLE, RUN, SETTLE}.
  - Constant `MUL_LATENCY`=5.
- Sub-module `rr_arb2`: combinational two-way round-robin grant with a registered `last` pointer and an update-on-accept input.
- The `mul` instance sits outside `mul_arbiter`; a thin wrapper ties the two together.

## Test plan
- Single request on port 0, MUL 7×6:
  - `req0_ready` high at E0.
  - `resp0_result`=42 with `resp0_valid` in C5.
  - `mul_start` high for exactly C1–C3.
- MULH on port 1, op1=0xFFFFFFFD (−3), op2=5 → `resp1_result`=0xFFFFFFFF, which confirms the inverted-product capture timing.
- Both ports continuously valid with MULHU 0xFFFFFFFF×0xFFFFFFFF and `resp*_ready`=1:
  - Grants alternate 0,1,0,1.
  - Each response is 0xFFFFFFFE.
  - Accept spacing is exactly 5 cycles.
- `resp0_ready`=0 while both ports request:
  - After the first port-0 result, only port 1 is granted.
  - Port 0 regains a grant the cycle after its response is popped.
- `rst_n` low for one cycle during RUN:
  - Next cycle state is IDLE, `mul_start`=0, no `resp_valid`.
  - A fresh MUL 3×3 then returns 9.
